// File: rtl/hazard_fwd_ctrl.sv
// Forwarding-select and load-use hazard controller for the five-stage pipeline.
// Tracks EX/MEM destination records and produces registered EX operand-mux selects.
module hazard_fwd_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic [4:0]       id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [1:0] SelRf  = 2'd0;
    localparam logic [1:0] SelWb  = 2'd1;
    localparam logic [1:0] SelMem = 2'd2;

    logic             ex_valid_q, ex_regwrite_q, ex_memread_q;
    logic [4:0]       ex_rd_q;
    // A producer in WB is resolved by the register file's write-before-read,
    // so no WB record is needed to drive any output.
    logic             mem_valid_q, mem_regwrite_q;
    logic [4:0]       mem_rd_q;
    logic [1:0]       fwd_a_q, fwd_b_q;
    logic [CNT_W-1:0] stall_cnt_q;

    logic [1:0] sel_a_d, sel_b_d;
    logic       ex_wr_rs, ex_wr_rt, mem_wr_rs, mem_wr_rt;

    always_comb begin
        ex_wr_rs  = ex_valid_q && ex_regwrite_q && (ex_rd_q == id_rs) && (id_rs != 5'd0);
        ex_wr_rt  = ex_valid_q && ex_regwrite_q && (ex_rd_q == id_rt) && (id_rt != 5'd0);
        mem_wr_rs = mem_valid_q && mem_regwrite_q && (mem_rd_q == id_rs) && (id_rs != 5'd0);
        mem_wr_rt = mem_valid_q && mem_regwrite_q && (mem_rd_q == id_rt) && (id_rt != 5'd0);

        stall = id_valid && !flush && ex_valid_q && ex_memread_q && (ex_rd_q != 5'd0) &&
                ((ex_rd_q == id_rs) || (id_uses_rt && (ex_rd_q == id_rt)));

        // EX beats MEM: the most recent producer must win.
        sel_a_d = SelRf;
        if (ex_wr_rs) begin
            sel_a_d = SelMem;
        end else if (mem_wr_rs) begin
            sel_a_d = SelWb;
        end

        sel_b_d = SelRf;
        if (id_uses_rt) begin
            if (ex_wr_rt) begin
                sel_b_d = SelMem;
            end else if (mem_wr_rt) begin
                sel_b_d = SelWb;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q     <= 1'b0;
            ex_regwrite_q  <= 1'b0;
            ex_memread_q   <= 1'b0;
            ex_rd_q        <= 5'd0;
            mem_valid_q    <= 1'b0;
            mem_regwrite_q <= 1'b0;
            mem_rd_q       <= 5'd0;
            fwd_a_q        <= SelRf;
            fwd_b_q        <= SelRf;
            stall_cnt_q    <= '0;
        end else if (!hold) begin
            mem_valid_q    <= ex_valid_q;
            mem_regwrite_q <= ex_regwrite_q;
            mem_rd_q       <= ex_rd_q;
            if (flush || stall) begin
                ex_valid_q <= 1'b0;
                fwd_a_q    <= SelRf;
                fwd_b_q    <= SelRf;
                if (stall && (stall_cnt_q != '1)) begin
                    stall_cnt_q <= stall_cnt_q + 1'b1;
                end
            end else begin
                ex_valid_q    <= id_valid;
                ex_regwrite_q <= id_regwrite;
                ex_memread_q  <= id_memread;
                ex_rd_q       <= id_rd;
                fwd_a_q       <= sel_a_d;
                fwd_b_q       <= sel_b_d;
            end
        end
    end

    assign fwd_a     = fwd_a_q;
    assign fwd_b     = fwd_b_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed self-checking bench for hazard_fwd_ctrl (CNT_W = 4 to reach saturation quickly).
module tb_hazard_fwd_ctrl;

    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst, hold, flush;
    logic             id_valid, id_uses_rt, id_regwrite, id_memread;
    logic [4:0]       id_rs, id_rt, id_rd;
    logic [1:0]       fwd_a, fwd_b;
    logic             stall;
    logic [CNT_W-1:0] stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    hazard_fwd_ctrl #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .hold       (hold),
        .flush      (flush),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rt (id_uses_rt),
        .id_rd      (id_rd),
        .id_regwrite(id_regwrite),
        .id_memread (id_memread),
        .fwd_a      (fwd_a),
        .fwd_b      (fwd_b),
        .stall      (stall),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urt, input logic [4:0] rd, input logic rw,
                          input logic mr);
        id_valid    = v;
        id_rs       = rs;
        id_rt       = rt;
        id_uses_rt  = urt;
        id_rd       = rd;
        id_regwrite = rw;
        id_memread  = mr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        nop();
        tick();
        tick();
    endtask

    // Common instruction shapes
    task automatic alu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        set_id(1'b1, rs, rt, 1'b1, rd, 1'b1, 1'b0);
    endtask

    task automatic lw(input logic [4:0] rd, input logic [4:0] base);
        set_id(1'b1, base, rd, 1'b0, rd, 1'b1, 1'b1);
    endtask

    initial begin
        rst   = 1'b1;
        hold  = 1'b0;
        flush = 1'b0;
        set_id(1'b1, 5'($urandom), 5'($urandom), 1'b1, 5'($urandom), 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'($urandom), 5'($urandom), 1'b1, 5'($urandom), 1'b1, 1'b1);
        tick();
        check("rst_fwd_a", 32'(fwd_a), 0);
        check("rst_fwd_b", 32'(fwd_b), 0);
        check("rst_stall", 32'(stall), 0);
        check("rst_cnt", 32'(stall_cnt), 0);
        rst = 1'b0;
        drain();

        // add $3,$1,$2 ; sub $4,$3,$3
        alu(5'd3, 5'd1, 5'd2);
        check("b2b_stall0", 32'(stall), 0);
        tick();
        alu(5'd4, 5'd3, 5'd3);
        check("b2b_stall1", 32'(stall), 0);
        tick();
        check("b2b_fwd_a", 32'(fwd_a), 2);
        check("b2b_fwd_b", 32'(fwd_b), 2);
        drain();

        // add $5 ; nop ; or $6,$5,$0
        alu(5'd5, 5'd1, 5'd2);
        tick();
        nop();
        tick();
        alu(5'd6, 5'd5, 5'd0);
        tick();
        check("dist2_fwd_a", 32'(fwd_a), 1);
        check("dist2_fwd_b", 32'(fwd_b), 0);
        drain();

        // add $5 ; add $5 ; or $6,$5 -> EX producer wins
        alu(5'd5, 5'd1, 5'd2);
        tick();
        alu(5'd5, 5'd3, 5'd4);
        tick();
        alu(5'd6, 5'd5, 5'd5);
        tick();
        check("prio_fwd_a", 32'(fwd_a), 2);
        check("prio_fwd_b", 32'(fwd_b), 2);
        drain();

        // writer of $0 then reader of $0
        alu(5'd0, 5'd1, 5'd2);
        tick();
        alu(5'd9, 5'd0, 5'd0);
        tick();
        check("r0_fwd_a", 32'(fwd_a), 0);
        check("r0_fwd_b", 32'(fwd_b), 0);
        drain();

        // add $1 ; lw $7,0($1) ; add $8,$7,$2
        alu(5'd1, 5'd2, 5'd3);
        tick();
        lw(5'd7, 5'd1);
        check("lu_lw_stall", 32'(stall), 0);
        tick();
        check("lu_lw_fwd_a", 32'(fwd_a), 2);
        alu(5'd8, 5'd7, 5'd2);
        check("lu_stall", 32'(stall), 1);
        tick();
        check("lu_bubble_a", 32'(fwd_a), 0);
        check("lu_bubble_b", 32'(fwd_b), 0);
        check("lu_cnt", 32'(stall_cnt), 1);
        check("lu_stall_once", 32'(stall), 0);
        tick();
        check("lu_add_fwd_a", 32'(fwd_a), 1);
        check("lu_add_fwd_b", 32'(fwd_b), 0);
        check("lu_cnt2", 32'(stall_cnt), 1);
        drain();

        // Flush in the hazard cycle squashes without counting
        alu(5'd1, 5'd2, 5'd3);
        tick();
        lw(5'd7, 5'd1);
        tick();
        check("fl_lw_fwd_a", 32'(fwd_a), 2);
        alu(5'd8, 5'd7, 5'd2);
        flush = 1'b1;
        #1;
        check("fl_stall", 32'(stall), 0);
        tick();
        flush = 1'b0;
        check("fl_fwd_a", 32'(fwd_a), 0);
        check("fl_fwd_b", 32'(fwd_b), 0);
        check("fl_cnt", 32'(stall_cnt), 1);
        drain();

        // Hold for 3 cycles during a stall
        alu(5'd1, 5'd2, 5'd3);
        tick();
        lw(5'd7, 5'd1);
        tick();
        alu(5'd8, 5'd7, 5'd2);
        check("hd_stall_pre", 32'(stall), 1);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("hd_fwd_a_%0d", i), 32'(fwd_a), 2);
            check($sformatf("hd_stall_%0d", i), 32'(stall), 1);
            check($sformatf("hd_cnt_%0d", i), 32'(stall_cnt), 1);
        end
        hold = 1'b0;
        tick();
        check("hd_bubble_a", 32'(fwd_a), 0);
        check("hd_cnt_post", 32'(stall_cnt), 2);
        check("hd_stall_post", 32'(stall), 0);
        tick();
        check("hd_add_fwd_a", 32'(fwd_a), 1);
        drain();

        // 20 load-use pairs: counter saturates at 15
        for (int i = 0; i < 20; i++) begin
            lw(5'd7, 5'd1);
            tick();
            alu(5'd8, 5'd7, 5'd2);
            check($sformatf("sat_stall_%0d", i), 32'(stall), 1);
            tick();
            tick();
        end
        check("sat_cnt", 32'(stall_cnt), 15);
        drain();
        check("sat_cnt_hold", 32'(stall_cnt), 15);

        // Reset beats hold mid-stall
        alu(5'd1, 5'd2, 5'd3);
        tick();
        lw(5'd7, 5'd1);
        tick();
        alu(5'd8, 5'd7, 5'd2);
        check("rh_stall_pre", 32'(stall), 1);
        hold = 1'b1;
        rst  = 1'b1;
        tick();
        check("rh_fwd_a", 32'(fwd_a), 0);
        check("rh_cnt", 32'(stall_cnt), 0);
        check("rh_stall", 32'(stall), 0);
        hold = 1'b0;
        rst  = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
